// File: rtl/bilateral_pkg.sv
// Shared types and constants for the bilateral-filter pipeline.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package bilateral_pkg;

    localparam int KSIZE = 7;
    localparam int N     = KSIZE * KSIZE;
    localparam int IDX_W = $clog2(N);
    localparam int PIX_W = 8;

    typedef logic [31:0]      fp32_t;
    typedef logic [PIX_W-1:0] pix_t;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } seq_state_e;

endpackage

// File: rtl/window_weight_sequencer.sv
// Serialises a KSIZE x KSIZE pixel window into N ordered beats of {weight, pixel, centre}.
// Latency: beat 0 is valid the cycle after the window is accepted; one beat per cycle after.
// Backpressure: out_ready low stalls the stream with every out_* held; in_ready only in IDLE.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   kernel                   N float32 spatial weights, row-major, treated as static
//   in_valid/in_ready        window handshake, in_window = N pixels row-major
//   out_valid/out_ready      beat handshake
//   out_weight, out_pixel    kernel[out_idx], window[out_idx]
//   out_center               window[N/2] for the whole window
//   out_idx, out_last        beat index, high on the final beat
//   busy                     high while streaming
module window_weight_sequencer
    import bilateral_pkg::fp32_t, bilateral_pkg::seq_state_e,
           bilateral_pkg::IDLE, bilateral_pkg::STREAM;
#(
    parameter int  KSIZE = 7,
    parameter int  PIX_W = 8,
    localparam int N     = KSIZE * KSIZE,
    localparam int IDX_W = $clog2(N)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N-1:0][31:0]        kernel,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [N-1:0][PIX_W-1:0]   in_window,
    output logic                      out_valid,
    input  logic                      out_ready,
    output fp32_t                     out_weight,
    output logic [PIX_W-1:0]          out_pixel,
    output logic [PIX_W-1:0]          out_center,
    output logic [IDX_W-1:0]          out_idx,
    output logic                      out_last,
    output logic                      busy
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    seq_state_e state_q;
    seq_state_e state_d;

    logic [N-1:0][PIX_W-1:0] win_q;
    logic [IDX_W-1:0]        idx_nxt;
    logic                    accept;
    logic                    advance;
    logic                    finish;

    // out_idx doubles as the beat counter; it is only advanced below LAST_IDX,
    // so idx_nxt is always in range whenever it is used.
    assign idx_nxt = out_idx + IDX_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        advance = 1'b0;
        finish  = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    accept  = 1'b1;
                    state_d = STREAM;
                end
            end
            STREAM: begin
                if (out_ready) begin
                    if (out_idx == LAST_IDX) begin
                        finish  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        advance = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == STREAM);
    assign busy      = (state_q == STREAM);

    // Window storage is pure datapath: it is only read while STREAM, which
    // always follows a load, so it needs no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            win_q <= in_window;
        end
    end

    // Beat 0 is taken straight from the incoming window on the accept edge so
    // it can be presented in the very next cycle; later beats read win_q.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_weight <= '0;
            out_pixel  <= '0;
            out_center <= '0;
            out_idx    <= '0;
            out_last   <= 1'b0;
        end else if (accept) begin
            out_weight <= kernel[0];
            out_pixel  <= in_window[0];
            out_center <= in_window[N/2];
            out_idx    <= '0;
            out_last   <= (N == 1);
        end else if (advance) begin
            out_weight <= kernel[idx_nxt];
            out_pixel  <= win_q[idx_nxt];
            out_idx    <= idx_nxt;
            out_last   <= (idx_nxt == LAST_IDX);
        end else if (finish) begin
            out_weight <= '0;
            out_pixel  <= '0;
            out_center <= '0;
            out_idx    <= '0;
            out_last   <= 1'b0;
        end
    end

endmodule
